// File: rtl/inst_queue_ctrl.sv
// inst_queue_ctrl: fetch-to-decode instruction queue with mispredict redirect and flush squash
module inst_queue_ctrl #(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_inst,
    input  logic        if_pred_taken,
    input  logic [31:0] if_pred_target,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_pred_taken,
    output logic [31:0] id_pred_target,
    input  logic        dec_br_mistaken,
    input  logic        dec_br_nop,
    input  logic [31:0] dec_br_target,
    output logic        redirect_valid,
    input  logic        redirect_ready,
    output logic [31:0] redirect_pc
);
    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] REDIR = 1'b1;
    logic [31:0]      pc_mem     [DEPTH];
    logic [31:0]      inst_mem   [DEPTH];
    logic             taken_mem  [DEPTH];
    logic [31:0]      target_mem [DEPTH];
    logic [0:0]       state_q, state_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic             enq, deq, mis;
    assign if_ready       = state_q == RUN && count_q < (PTR_W+1)'(DEPTH);
    assign id_valid       = state_q == RUN && count_q != '0;
    assign enq            = if_valid && if_ready;
    assign deq            = id_valid && id_ready;
    assign mis            = deq && dec_br_mistaken;
    assign id_pc          = pc_mem[rd_ptr_q];
    assign id_inst        = inst_mem[rd_ptr_q];
    assign id_pred_taken  = taken_mem[rd_ptr_q];
    assign id_pred_target = target_mem[rd_ptr_q];
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    always_comb begin
        state_d          = state_q;
        count_d          = count_q;
        rd_ptr_d         = rd_ptr_q;
        wr_ptr_d         = wr_ptr_q;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        if (flush) begin
            state_d          = RUN;
            count_d          = '0;
            rd_ptr_d         = '0;
            wr_ptr_d         = '0;
            redirect_valid_d = 1'b0;
        end else if (state_q == REDIR) begin
            if (redirect_valid_q && redirect_ready) begin
                state_d          = RUN;
                redirect_valid_d = 1'b0;
            end
        end else if (mis) begin
            // the branch itself leaves; everything younger, including this cycle's fetch, is squashed
            state_d          = REDIR;
            count_d          = '0;
            rd_ptr_d         = '0;
            wr_ptr_d         = '0;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = dec_br_nop ? id_pc + 32'd4 : dec_br_target;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(enq);
            rd_ptr_d = rd_ptr_q + PTR_W'(deq);
            count_d  = count_q + (PTR_W+1)'(enq) - (PTR_W+1)'(deq);
        end
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q          <= RUN;
            count_q          <= '0;
            rd_ptr_q         <= '0;
            wr_ptr_q         <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            count_q          <= count_d;
            rd_ptr_q         <= rd_ptr_d;
            wr_ptr_q         <= wr_ptr_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end
    always_ff @(posedge clk) begin
        if (enq && !flush && !mis) begin
            pc_mem[wr_ptr_q]     <= if_pc;
            inst_mem[wr_ptr_q]   <= if_inst;
            taken_mem[wr_ptr_q]  <= if_pred_taken;
            target_mem[wr_ptr_q] <= if_pred_target;
        end
    end
endmodule

// File: tb/tb_inst_queue_ctrl.sv
// tb_inst_queue_ctrl: directed checks of queueing, backpressure, redirect, flush and reset
module tb_inst_queue_ctrl;
    logic        clk = 1'b0;
    logic        resetn, flush, if_valid, if_ready, if_pred_taken;
    logic [31:0] if_pc, if_inst, if_pred_target;
    logic        id_valid, id_ready, id_pred_taken;
    logic [31:0] id_pc, id_inst, id_pred_target;
    logic        dec_br_mistaken, dec_br_nop;
    logic [31:0] dec_br_target;
    logic        redirect_valid, redirect_ready;
    logic [31:0] redirect_pc;
    int n_cmp = 0;
    int n_err = 0;

    inst_queue_ctrl dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
        .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst),
        .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target),
        .dec_br_mistaken(dec_br_mistaken), .dec_br_nop(dec_br_nop), .dec_br_target(dec_br_target),
        .redirect_valid(redirect_valid), .redirect_ready(redirect_ready), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic taken);
        if_valid = 1'b1;
        if_pc = pc;
        if_inst = ~pc;
        if_pred_taken = taken;
        if_pred_target = pc + 32'h40;
    endtask

    task automatic enq(input logic [31:0] pc, input logic taken);
        offer(pc, taken);
        tick();
        if_valid = 1'b0;
    endtask

    task automatic mispredict(input logic nop, input logic [31:0] tgt);
        id_ready = 1'b1;
        dec_br_mistaken = 1'b1;
        dec_br_nop = nop;
        dec_br_target = tgt;
        tick();
        id_ready = 1'b0;
        dec_br_mistaken = 1'b0;
        if_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_id_valid"}, id_valid, 0);
        check({tag, "_redir_valid"}, redirect_valid, 0);
        check({tag, "_redir_pc"}, redirect_pc, 0);
        check({tag, "_if_ready"}, if_ready, 1);
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0;
        if_pred_taken = 1'b0; if_pred_target = '0; id_ready = 1'b0;
        dec_br_mistaken = 1'b0; dec_br_nop = 1'b0; dec_br_target = '0; redirect_ready = 1'b0;
        tick(); tick();
        resetn = 1'b1;
        check_reset_outputs("rst");

        // 1: three entries, then drain in order
        for (int i = 0; i < 3; i++) enq(32'h1c000000 + 32'(4*i), 1'b0);
        check("t1_count", dut.count_q, 3);
        check("t1_head_pc", id_pc, 32'h1c000000);
        check("t1_head_inst", id_inst, ~32'h1c000000);
        check("t1_head_tgt", id_pred_target, 32'h1c000040);
        id_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t1_valid", id_valid, 1);
            check("t1_pc", id_pc, 32'h1c000000 + 32'(4*i));
            tick();
        end
        id_ready = 1'b0;
        check("t1_empty", id_valid, 0);

        // 2: fill, held 9th offer, one-cycle stall after dequeue, pointer wrap
        for (int i = 0; i < 8; i++) enq(32'h100 + 32'(4*i), 1'b0);
        check("t2_full_ready", if_ready, 0);
        check("t2_full_count", dut.count_q, 8);
        offer(32'h200, 1'b0);
        tick();
        check("t2_held_count", dut.count_q, 8);
        check("t2_held_ready", if_ready, 0);
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        check("t2_ready_after_deq", if_ready, 1);
        check("t2_count_after_deq", dut.count_q, 7);
        tick();
        if_valid = 1'b0;
        check("t2_refill_count", dut.count_q, 8);
        id_ready = 1'b1;
        for (int i = 1; i < 9; i++) begin
            check("t2_order", id_pc, i < 8 ? 32'h100 + 32'(4*i) : 32'h200);
            tick();
        end
        id_ready = 1'b0;
        check("t2_drained", id_valid, 0);

        // 3: mispredicted not-a-branch head with younger entries
        enq(32'h1c000010, 1'b1);
        enq(32'h1c000014, 1'b0);
        enq(32'h1c000018, 1'b0);
        check("t3_head_taken", id_pred_taken, 1);
        mispredict(1'b1, 32'hdeadbeef);
        for (int i = 0; i < 3; i++) begin
            check("t3_redir_valid", redirect_valid, 1);
            check("t3_redir_pc", redirect_pc, 32'h1c000014);
            check("t3_if_ready", if_ready, 0);
            check("t3_id_valid", id_valid, 0);
            check("t3_count", dut.count_q, 0);
            if (i == 2) redirect_ready = 1'b1;
            tick();
        end
        redirect_ready = 1'b0;
        check("t3_accepted", redirect_valid, 0);
        check("t3_run_ready", if_ready, 1);

        // 4: mispredicted branch target; same-cycle fetch dropped
        enq(32'h1c000100, 1'b0);
        check("t4_head_taken", id_pred_taken, 0);
        offer(32'h1c000500, 1'b0);
        mispredict(1'b0, 32'h1c000400);
        check("t4_redir_pc", redirect_pc, 32'h1c000400);
        check("t4_redir_valid", redirect_valid, 1);
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        check("t4_no_enq_count", dut.count_q, 0);
        check("t4_no_enq_valid", id_valid, 0);

        // 5: flush cancels redirect; flush beats enq+deq
        enq(32'h1c000200, 1'b0);
        mispredict(1'b1, 32'h0);
        check("t5_redir_pending", redirect_valid, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_redir_cancel", redirect_valid, 0);
        check("t5_if_ready", if_ready, 1);
        enq(32'h1c000300, 1'b0);
        enq(32'h1c000304, 1'b0);
        offer(32'h1c000308, 1'b0);
        id_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0; id_ready = 1'b0; if_valid = 1'b0;
        check("t5_flush_count", dut.count_q, 0);
        check("t5_flush_valid", id_valid, 0);
        enq(32'h1c000600, 1'b0);
        check("t5_ptr_reset", id_pc, 32'h1c000600);
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;

        // 6: reset with a loaded queue, then with a redirect pending
        for (int i = 0; i < 5; i++) enq(32'h1c000700 + 32'(4*i), 1'b0);
        check("t6_count5", dut.count_q, 5);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check_reset_outputs("t6a");
        enq(32'h1c000800, 1'b0);
        check("t6_ptr_reset", id_pc, 32'h1c000800);
        mispredict(1'b1, 32'h0);
        check("t6_redir_pc", redirect_pc, 32'h1c000804);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check_reset_outputs("t6b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
